audio_capture: RTL and testbench
================================

Name: audio_capture

Overview:
- Read-side companion to the audio write path: drains samples from the audio_codec read interface (read_ready/read/readdata_left/readdata_right).
- Mixes the left and right channels to mono, buffers the result in a small FIFO, and exposes a pop interface to downstream logic.
- Also provides a peak-level meter with periodic decay and a saturating dropped-sample counter.
- Sits between audio_codec and any consumer, such as the game/FSM logic or a level display.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DECAY_CYCLES, 50000, clock cycles between peak decay steps (1 ms at 50 MHz).
- DROP_W, 8, width of the dropped-sample counter.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- resetn  input  1  asynchronous, active-low reset.
- read_ready  input  1  from audio_codec; a sample pair is available.
- readdata_left  input  24  signed left sample, valid while read_ready=1.
- readdata_right  input  24  signed right sample, valid while read_ready=1.
- read  output  1  to audio_codec; one-cycle pop strobe.
- enable  input  1  capture enable; 0 stops issuing reads.
- pop  input  1  consumer pop request.
- sample_out  output  24  FIFO head, signed mono; valid when sample_valid=1.
- sample_valid  output  1  FIFO not empty.
- fifo_full  output  1  FIFO holds DEPTH entries.
- peak  output  24  unsigned peak magnitude.
- drop_count  output  DROP_W  saturating count of samples dropped because the FIFO was full.
- clear_stats  input  1  synchronous clear of peak and drop_count.

Behaviour:
- Reset (resetn=0, asynchronous): read=0, sample_valid=0, fifo_full=0, sample_out=0, peak=0, drop_count=0, FSM=IDLE, FIFO pointers=0, decay timer=0.
- FSM states:
  - IDLE: if enable && read_ready, go to READ.
  - READ: read=1 for exactly this one cycle; readdata_left/right are captured on this edge; go to WAIT.
  - WAIT: read=0 for one cycle so read_ready can update; go to IDLE.
  - A sample is therefore consumed at most once every 3 cycles, far above the 48 kHz rate.
- Enable deasserted during READ or WAIT: the sequence completes; it only blocks the IDLE->READ transition.
- Mixing:
  - mono = (sext25(L) + sext25(R)) >>> 1, arithmetic shift, truncated to 24 bits. No overflow is possible.
  - Example: L=0x7FFFFF, R=0x7FFFFF gives 0x7FFFFF; L=0x800000, R=0x7FFFFF gives 0xFFFFFF (-1).
- Mixed sample is written to the FIFO one cycle after READ (registered mix), i.e. in the WAIT cycle.
- FIFO full at write time:
  - The sample is discarded; read is still issued so the codec keeps draining.
  - drop_count increments and saturates at all-ones.
- FIFO:
  - Pointer width is log2(DEPTH)+1, so wrap-around is handled without ambiguity.
  - sample_out is the head entry (combinational read of the registered array); sample_valid = !empty.
  - pop with empty is ignored.
  - Push and pop in the same cycle: allowed even when full. The pop frees a slot, so the push succeeds and there is no drop. Count is unchanged.
  - Pop takes effect at the clock edge; the next head appears the following cycle.
- Peak meter:
  - mag = |mono|; |0x800000| saturates to 0x7FFFFF.
  - On each mixed sample (dropped or not): peak = max(peak, mag).
  - Decay timer counts 0..DECAY_CYCLES-1; on wrap, peak = peak - (peak>>4), a 1/16 decay.
  - If decay and a sample update land in the same cycle, the sample max is applied to the decayed value.
- clear_stats:
  - Sets peak=0 and drop_count=0 next cycle and resets the decay timer.
  - Has priority over a same-cycle update; FIFO contents are untouched.

Decomposition:
- Package audio_pkg:
  - SAMPLE_W=24 constant.
  - Capture FSM state typedef (IDLE, READ, WAIT).
  - Function sat_abs24.
- One sub-module, sample_fifo:
  - Parameterised DEPTH and width.
  - Ports: push, pop, din, dout, empty, full.
  - Implements the same-cycle push/pop-when-full rule above.
- FSM, mixer, peak meter and counters live in audio_capture.

Test Plan:
1. Reset mid-READ: assert resetn=0 while read=1 -> read=0 immediately (asynchronous), all outputs 0, FSM IDLE; after release, first read occurs 1 cycle after read_ready is seen high.
2. Hold read_ready=1 with L=0x000100, R=0x000300 for 4 sample pops -> read pulses every 3 cycles; sample_out=0x000200, sample_valid=1, 4 entries queued.
3. No pops, read_ready held high -> fifo_full=1 after 8 samples; the next 3 samples give drop_count=3 with read still pulsing; with DROP_W=2, drop_count saturates at 3.
4. FIFO full, pop asserted in the same cycle as the mix write -> no drop, count stays 8, the new sample lands at the tail in order.
5. Single sample L=R=0x800000 -> mono=0x800000, peak=0x7FFFFF; with DECAY_CYCLES=4 and no further samples, peak becomes 0x780000 after 4 cycles; clear_stats gives peak=0 next cycle.
6. enable=0 with read_ready=1 -> read never asserts; setting enable=1 produces a read pulse 1 cycle later.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio read path: sample width, capture FSM
// encoding and the saturating magnitude helper used by the peak meter.
package audio_pkg;

   localparam int SAMPLE_W = 24;

   typedef logic [1:0] capState_t;

   localparam capState_t IDLE = 2'd0;
   localparam capState_t READ = 2'd1;
   localparam capState_t WAIT = 2'd2;

   // The most negative sample has no positive twin, so it clamps to full scale.
   function automatic logic [SAMPLE_W-1:0] sat_abs24(input logic [SAMPLE_W-1:0] x);
      logic [SAMPLE_W-1:0] r;
      if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
         r = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else if (x[SAMPLE_W-1])
         r = -x;
      else
         r = x;
      return r;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for mono samples; a pop frees a slot for a push
// landing in the same cycle, so a full FIFO that is being drained never drops.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = SAMPLE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPush;
   logic             doPop;

   // The extra pointer bit tells a full FIFO apart from an empty one.
   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign dout   = empty ? '0 : mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush)
            wrPtr <= wrPtr + PTR_ONE;
         if (doPop)
            rdPtr <= rdPtr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush)
         mem[wrPtr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/audio_capture.sv
// Drains stereo samples from the codec read port, mixes them to mono into a
// FIFO for downstream consumers, and keeps a decaying peak meter and drop count.
module audio_capture
   import audio_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int DECAY_CYCLES = 50000,
   parameter int DROP_W       = 8
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                read_ready,
   input  logic [SAMPLE_W-1:0] readdata_left,
   input  logic [SAMPLE_W-1:0] readdata_right,
   output logic                read,
   input  logic                enable,
   input  logic                pop,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                fifo_full,
   output logic [SAMPLE_W-1:0] peak,
   output logic [DROP_W-1:0]   drop_count,
   input  logic                clear_stats
);

   localparam int TIMER_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DECAY_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
   localparam logic [DROP_W-1:0]  DROP_ONE   = DROP_W'(1);

   capState_t            state;
   capState_t            stateNext;
   logic [SAMPLE_W-1:0]  mixHalf;
   logic [SAMPLE_W-1:0]  mixReg;
   logic                 mixValid;
   logic                 fifoEmpty;
   logic                 dropNow;
   logic [TIMER_W-1:0]   decayTimer;
   logic                 decayTick;
   logic [SAMPLE_W-1:0]  mixMag;
   logic [SAMPLE_W-1:0]  peakBase;
   logic [SAMPLE_W-1:0]  peakNext;

   assign read = (state == READ);

   // The WAIT cycle gives the codec time to retire the pair before read_ready is re-examined.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (enable && read_ready) stateNext = READ;
         READ:    stateNext = WAIT;
         WAIT:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // floor((L+R)/2) built from pre-halved operands plus the shared low-bit carry,
   // which keeps the whole sum inside 24 bits.
   assign mixHalf = {readdata_left[SAMPLE_W-1], readdata_left[SAMPLE_W-1:1]}
                  + {readdata_right[SAMPLE_W-1], readdata_right[SAMPLE_W-1:1]}
                  + {{(SAMPLE_W-1){1'b0}}, readdata_left[0] & readdata_right[0]};

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         mixReg   <= '0;
         mixValid <= 1'b0;
      end else begin
         mixValid <= (state == READ);
         if (state == READ)
            mixReg <= mixHalf;
      end
   end

   sample_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SAMPLE_W)
   ) fifo (
      .clk   (CLOCK_50),
      .rst_n (resetn),
      .push  (mixValid),
      .pop   (pop),
      .din   (mixReg),
      .dout  (sample_out),
      .empty (fifoEmpty),
      .full  (fifo_full)
   );

   assign sample_valid = !fifoEmpty;
   assign dropNow      = mixValid && fifo_full && !pop;

   assign decayTick = (decayTimer == TIMER_LAST);
   assign mixMag    = sat_abs24(mixReg);
   assign peakBase  = decayTick ? (peak - (peak >> 4)) : peak;
   assign peakNext  = (mixValid && (mixMag > peakBase)) ? mixMag : peakBase;

   // Statistics: clear_stats wins over any decay, peak or drop update in the same cycle.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         decayTimer <= '0;
         peak       <= '0;
         drop_count <= '0;
      end else if (clear_stats) begin
         decayTimer <= '0;
         peak       <= '0;
         drop_count <= '0;
      end else begin
         decayTimer <= decayTick ? '0 : decayTimer + TIMER_ONE;
         peak       <= peakNext;
         if (dropNow && (drop_count != '1))
            drop_count <= drop_count + DROP_ONE;
      end
   end

endmodule

// File: tb/tb_audio_capture.sv
// Self-checking bench for audio_capture: directed scenarios followed by a
// randomized codec/consumer phase, all checked against a queue-based model.
module tb_audio_capture;

   localparam int DEPTH  = 8;
   localparam int DECAY  = 4;
   localparam int DROP_W = 2;

   logic              CLOCK_50 = 1'b0;
   logic              resetn = 1'b0;
   logic              read_ready = 1'b0;
   logic [23:0]       readdata_left = '0;
   logic [23:0]       readdata_right = '0;
   logic              read;
   logic              enable = 1'b0;
   logic              pop = 1'b0;
   logic [23:0]       sample_out;
   logic              sample_valid;
   logic              fifo_full;
   logic [23:0]       peak;
   logic [DROP_W-1:0] drop_count;
   logic              clear_stats = 1'b0;

   int checks = 0;
   int errors = 0;

   int expQ[$];
   int peakM;
   int dropM;
   int cycM;
   bit pendM;
   int pendValM;
   bit sawRead;
   int tickNum = 0;

   audio_capture #(
      .DEPTH        (DEPTH),
      .DECAY_CYCLES (DECAY),
      .DROP_W       (DROP_W)
   ) dut (
      .CLOCK_50       (CLOCK_50),
      .resetn         (resetn),
      .read_ready     (read_ready),
      .readdata_left  (readdata_left),
      .readdata_right (readdata_right),
      .read           (read),
      .enable         (enable),
      .pop            (pop),
      .sample_out     (sample_out),
      .sample_valid   (sample_valid),
      .fifo_full      (fifo_full),
      .peak           (peak),
      .drop_count     (drop_count),
      .clear_stats    (clear_stats)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no end of run, required $finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int mixModel(input logic [23:0] l, input logic [23:0] r);
      int a;
      int b;
      a = int'($signed(l));
      b = int'($signed(r));
      return (a + b) >>> 1;
   endfunction

   function automatic int magModel(input int m);
      if (m == -8388608) return 8388607;
      return (m < 0) ? -m : m;
   endfunction

   function automatic logic [23:0] pickSample();
      case ($urandom_range(0, 5))
         0:       return 24'h800000;
         1:       return 24'h7FFFFF;
         default: return 24'($urandom);
      endcase
   endfunction

   task automatic resetModel();
      expQ.delete();
      peakM   = 0;
      dropM   = 0;
      cycM    = 0;
      pendM   = 1'b0;
      sawRead = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      logic [23:0] headExp;
      headExp = '0;
      if (expQ.size() > 0) headExp = 24'(expQ[0]);
      checkOutput("sample_valid", sample_valid, expQ.size() > 0);
      checkOutput("fifo_full", fifo_full, expQ.size() == DEPTH);
      checkOutput("sample_out", sample_out, headExp);
      checkOutput("peak", peak, peakM);
      checkOutput("drop_count", drop_count, dropM);
   endtask

   // One clock of stimulus: inputs seen before the edge drive the model update.
   task automatic applyStimulus();
      bit rd;
      bit pp;
      bit clr;
      logic [23:0] l;
      logic [23:0] r;
      int base;
      int mag;
      rd  = read;
      pp  = pop;
      clr = clear_stats;
      l   = readdata_left;
      r   = readdata_right;
      @(posedge CLOCK_50);
      tickNum++;
      cycM++;
      if (pp && expQ.size() > 0) void'(expQ.pop_front());
      if (pendM) begin
         if (expQ.size() < DEPTH) expQ.push_back(pendValM);
         else if (!clr && dropM < (1 << DROP_W) - 1) dropM++;
      end
      if (clr) begin
         peakM = 0;
         dropM = 0;
         cycM  = 0;
      end else begin
         base = peakM;
         if (cycM % DECAY == 0) base = peakM - peakM / 16;
         if (pendM) begin
            mag = magModel(pendValM);
            if (mag > base) base = mag;
         end
         peakM = base;
      end
      pendM = rd;
      if (rd) pendValM = mixModel(l, r);
      sawRead = rd;
      #1;
      checkAll();
   endtask

   initial begin
      int guard;
      int prevRead;
      int readsSeen;
      logic [23:0] lastOut;

      resetModel();
      repeat (2) @(posedge CLOCK_50);
      #1;
      checkOutput("reset_read", read, 0);
      checkAll();
      resetn = 1'b1;

      // Reset arriving while read is high must clear everything at once.
      enable = 1'b1;
      readdata_left  = 24'h000100;
      readdata_right = 24'h000300;
      read_ready = 1'b1;
      applyStimulus();
      checkOutput("first_read", read, 1);
      #2 resetn = 1'b0;
      #1;
      resetModel();
      checkOutput("async_reset_read", read, 0);
      checkAll();
      read_ready = 1'b0;
      @(posedge CLOCK_50);
      #1;
      checkOutput("reset_held_read", read, 0);
      resetn = 1'b1;
      applyStimulus();
      checkOutput("idle_no_ready", read, 0);
      read_ready = 1'b1;
      applyStimulus();
      checkOutput("read_after_release", read, 1);

      $display("[TB] steady capture of L=0x100 R=0x300");
      prevRead = tickNum;
      guard = 0;
      while (expQ.size() < 4 && guard < 40) begin
         applyStimulus();
         guard++;
         if (read) begin
            checkOutput("read_period", tickNum - prevRead, 3);
            prevRead = tickNum;
         end
      end
      checkOutput("four_queued_in_time", guard < 40, 1);
      checkOutput("mono_0x200", sample_out, 24'h000200);
      checkOutput("four_valid", sample_valid, 1);

      $display("[TB] fill without pops, then overflow");
      guard = 0;
      while (expQ.size() < DEPTH && guard < 60) begin
         applyStimulus();
         guard++;
      end
      checkOutput("fill_in_time", guard < 60, 1);
      checkOutput("full_flag", fifo_full, 1);
      guard = 0;
      readsSeen = 0;
      while (dropM < 3 && guard < 60) begin
         applyStimulus();
         guard++;
         if (read) readsSeen++;
      end
      checkOutput("drops_in_time", guard < 60, 1);
      checkOutput("drop_three", drop_count, 2'b11);
      repeat (9) begin
         applyStimulus();
         if (read) readsSeen++;
      end
      checkOutput("drop_saturated", drop_count, 2'b11);
      checkOutput("reads_while_full", readsSeen >= 3, 1);

      $display("[TB] push and pop together while full");
      read_ready = 1'b0;
      repeat (4) applyStimulus();
      clear_stats = 1'b1;
      applyStimulus();
      clear_stats = 1'b0;
      checkOutput("drop_cleared", drop_count, 0);
      readdata_left  = 24'h001000;
      readdata_right = 24'h003000;
      read_ready = 1'b1;
      guard = 0;
      sawRead = 1'b0;
      while (!sawRead && guard < 10) begin
         applyStimulus();
         guard++;
      end
      checkOutput("capture_in_time", guard < 10, 1);
      read_ready = 1'b0;
      pop = 1'b1;
      applyStimulus();
      pop = 1'b0;
      checkOutput("full_after_pushpop", fifo_full, 1);
      checkOutput("no_drop_pushpop", drop_count, 0);
      pop = 1'b1;
      lastOut = '0;
      repeat (DEPTH) begin
         lastOut = sample_out;
         applyStimulus();
      end
      pop = 1'b0;
      checkOutput("tail_value", lastOut, 24'h002000);
      checkOutput("drained_empty", sample_valid, 0);

      $display("[TB] peak saturation and decay");
      clear_stats = 1'b1;
      applyStimulus();
      clear_stats = 1'b0;
      checkOutput("peak_cleared", peak, 0);
      readdata_left  = 24'h800000;
      readdata_right = 24'h800000;
      read_ready = 1'b1;
      applyStimulus();
      checkOutput("peak_read", read, 1);
      applyStimulus();
      read_ready = 1'b0;
      applyStimulus();
      checkOutput("mono_min", sample_out, 24'h800000);
      checkOutput("peak_sat", peak, 24'h7FFFFF);
      applyStimulus();
      checkOutput("peak_decay", peak, 24'h780000);
      clear_stats = 1'b1;
      applyStimulus();
      clear_stats = 1'b0;
      checkOutput("peak_clear_again", peak, 0);
      pop = 1'b1;
      applyStimulus();
      pop = 1'b0;

      $display("[TB] enable gating");
      enable = 1'b0;
      read_ready = 1'b1;
      repeat (10) begin
         applyStimulus();
         checkOutput("no_read_disabled", read, 0);
      end
      enable = 1'b1;
      applyStimulus();
      checkOutput("read_on_enable", read, 1);
      applyStimulus();
      applyStimulus();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 800; i++) begin
         enable      = ($urandom_range(0, 9) != 0);
         pop         = (i >= 200 && i < 400) ? ($urandom_range(0, 9) == 0)
                                             : ($urandom_range(0, 9) < 4);
         clear_stats = ($urandom_range(0, 59) == 0);
         if (sawRead) begin
            readdata_left  = pickSample();
            readdata_right = pickSample();
         end
         if (sawRead || !read_ready || $urandom_range(0, 7) == 0)
            read_ready = ($urandom_range(0, 3) != 0);
         applyStimulus();
      end
      pop = 1'b0;
      clear_stats = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
